// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Pipeline sequencer for the 5-stage CPU. Drives PC / IF/ID
//               write enables and IF/ID, ID/EX, EX/MEM flush/hold lines from
//               load-use hazards, data-memory wait states and MEM-stage PC
//               redirects. Flags sticky memory timeouts and counts stall
//               cycles (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int unsigned REG_W     = 6,
    parameter int unsigned LU_CYCLES = 1,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             exmem_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] c_LU_CYCLES = 2'(LU_CYCLES);
    localparam logic [7:0] c_TIMEOUT   = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MWAIT   = 2'd2,
        ERR     = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_eff;
    state_t           w_state_next;
    logic [1:0]       r_lu_cnt;
    logic [1:0]       w_lu_cnt_next;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_next;
    logic             r_mem_timeout;
    logic             w_timeout_set;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             w_load_use;
    logic             w_mem_wait;
    logic             w_run_eval;
    logic             w_in_ldstall;

    // Hazard and memory-wait detection from the current pipeline contents
    always_comb begin
        w_load_use = ex_mem_read &&
                     ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
        w_mem_wait = mem_req && !mem_ready;
    end

    // Next-state and control outputs; a cycle under reset is decoded as RUN
    always_comb begin
        w_state_eff     = rst_n ? r_state : RUN;
        w_state_next    = w_state_eff;
        w_lu_cnt_next   = r_lu_cnt;
        w_wait_cnt_next = r_wait_cnt;
        w_timeout_set   = 1'b0;
        pc_write        = 1'b1;
        ifid_write      = 1'b1;
        ifid_flush      = 1'b0;
        idex_flush      = 1'b0;
        exmem_flush     = 1'b0;
        exmem_hold      = 1'b0;

        // A released memory wait behaves exactly like RUN for this cycle
        w_run_eval   = (w_state_eff == RUN) || (w_state_eff == LDSTALL) ||
                       ((w_state_eff == MWAIT) && mem_ready);
        w_in_ldstall = (w_state_eff == LDSTALL);

        if (w_state_eff == ERR) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
        end else if (!w_run_eval) begin
            // Still waiting on memory; redirect stays parked in EX/MEM
            pc_write        = 1'b0;
            ifid_write      = 1'b0;
            exmem_hold      = 1'b1;
            w_wait_cnt_next = r_wait_cnt + 8'd1;
            if ((r_wait_cnt + 8'd1) == c_TIMEOUT) begin
                w_state_next  = ERR;
                w_timeout_set = 1'b1;
            end
        end else begin
            w_wait_cnt_next = 8'd0;
            if (w_mem_wait) begin
                pc_write        = 1'b0;
                ifid_write      = 1'b0;
                exmem_hold      = 1'b1;
                w_state_next    = MWAIT;
                w_wait_cnt_next = 8'd1;
                w_lu_cnt_next   = 2'd0;
            end else if (redirect) begin
                ifid_flush    = 1'b1;
                idex_flush    = 1'b1;
                exmem_flush   = 1'b1;
                w_state_next  = RUN;
                w_lu_cnt_next = 2'd0;
            end else if (w_in_ldstall && (r_lu_cnt < c_LU_CYCLES)) begin
                pc_write      = 1'b0;
                ifid_write    = 1'b0;
                idex_flush    = 1'b1;
                w_lu_cnt_next = r_lu_cnt + 2'd1;
                w_state_next  = LDSTALL;
            end else if (w_in_ldstall) begin
                // Last bubble issued: release without re-checking the hazard
                w_lu_cnt_next = 2'd0;
                w_state_next  = RUN;
            end else if (w_load_use) begin
                pc_write      = 1'b0;
                ifid_write    = 1'b0;
                idex_flush    = 1'b1;
                w_lu_cnt_next = 2'd1;
                w_state_next  = LDSTALL;
            end else begin
                w_state_next = RUN;
            end
        end
    end

    // State, counters and sticky flag register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_lu_cnt       <= 2'd0;
            r_wait_cnt     <= 8'd0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state       <= w_state_next;
            r_lu_cnt      <= w_lu_cnt_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_mem_timeout <= r_mem_timeout | w_timeout_set;
            if (!pc_write && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Self-checking bench for hazard_stall_ctrl. Two instances with
//               different LU_CYCLES / TIMEOUT / CNT_W share one stimulus and
//               are compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int REG_W = 6;

    // Control vector order: {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, exmem_hold}
    localparam logic [5:0] K_NORMAL = 6'b110000;
    localparam logic [5:0] K_FREEZE = 6'b000001;
    localparam logic [5:0] K_REDIR  = 6'b111110;
    localparam logic [5:0] K_BUBBLE = 6'b000100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_use_rs, id_use_rt, ex_mem_read, redirect, mem_req, mem_ready;

    logic        pc_write_a, ifid_write_a, ifid_flush_a, idex_flush_a, exmem_flush_a, exmem_hold_a, mem_timeout_a;
    logic [15:0] stall_a;
    logic        pc_write_b, ifid_write_b, ifid_flush_b, idex_flush_b, exmem_flush_b, exmem_hold_b, mem_timeout_b;
    logic [3:0]  stall_b;

    hazard_stall_ctrl #(.REG_W(REG_W), .LU_CYCLES(1), .TIMEOUT(64), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .redirect(redirect),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write_a), .ifid_write(ifid_write_a),
        .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a), .exmem_flush(exmem_flush_a),
        .exmem_hold(exmem_hold_a), .mem_timeout(mem_timeout_a), .stall_cycles(stall_a)
    );

    hazard_stall_ctrl #(.REG_W(REG_W), .LU_CYCLES(2), .TIMEOUT(5), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .redirect(redirect),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write_b), .ifid_write(ifid_write_b),
        .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b), .exmem_flush(exmem_flush_b),
        .exmem_hold(exmem_hold_b), .mem_timeout(mem_timeout_b), .stall_cycles(stall_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model per instance: pipeline condition flags plus counts
    int  m_lu[2]  = '{1, 2};
    int  m_to[2]  = '{64, 5};
    int  m_sat[2] = '{65535, 15};
    bit  m_err[2];
    bit  m_waiting[2];
    int  m_wait_len[2];
    bit  m_in_lu[2];
    int  m_left[2];
    int  m_stalls[2];
    logic [5:0] exp_ctl[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model(input int k);
        m_err[k] = 0; m_waiting[k] = 0; m_wait_len[k] = 0; m_in_lu[k] = 0; m_left[k] = 0;
    endtask

    // Predict this cycle's controls from the rules, then advance the model
    task automatic eval_model(input int k);
        bit hz, mw;
        logic [5:0] kind;
        hz = ex_mem_read && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
        mw = mem_req && !mem_ready;
        if (!rst_n) clear_model(k);
        if (m_err[k]) begin
            kind = K_FREEZE;
        end else if (m_waiting[k] && !mem_ready) begin
            kind = K_FREEZE;
            m_wait_len[k]++;
            if (m_wait_len[k] == m_to[k]) begin
                m_err[k] = 1;
                m_waiting[k] = 0;
            end
        end else begin
            m_waiting[k] = 0;
            m_wait_len[k] = 0;
            if (mw) begin
                kind = K_FREEZE;
                m_waiting[k] = 1;
                m_wait_len[k] = 1;
                m_in_lu[k] = 0;
            end else if (redirect) begin
                kind = K_REDIR;
                m_in_lu[k] = 0;
            end else if (m_in_lu[k] && m_left[k] > 0) begin
                kind = K_BUBBLE;
                m_left[k]--;
            end else if (m_in_lu[k]) begin
                kind = K_NORMAL;
                m_in_lu[k] = 0;
            end else if (hz) begin
                kind = K_BUBBLE;
                m_in_lu[k] = 1;
                m_left[k] = m_lu[k] - 1;
            end else begin
                kind = K_NORMAL;
            end
        end
        exp_ctl[k] = kind;
        if ((kind == K_FREEZE || kind == K_BUBBLE) && m_stalls[k] < m_sat[k]) m_stalls[k]++;
        if (!rst_n) begin
            clear_model(k);
            m_stalls[k] = 0;
        end
    endtask

    // Per-cycle comparison: registered outputs first, then combinational controls
    task automatic check_cycle();
        chk("timeout_a", 32'(mem_timeout_a), 32'(m_err[0]));
        chk("stall_a",   32'(stall_a),       32'(m_stalls[0]));
        chk("timeout_b", 32'(mem_timeout_b), 32'(m_err[1]));
        chk("stall_b",   32'(stall_b),       32'(m_stalls[1]));
        eval_model(0);
        eval_model(1);
        chk("ctl_a", 32'({pc_write_a, ifid_write_a, ifid_flush_a, idex_flush_a, exmem_flush_a, exmem_hold_a}),
            32'(exp_ctl[0]));
        chk("ctl_b", 32'({pc_write_b, ifid_write_b, ifid_flush_b, idex_flush_b, exmem_flush_b, exmem_hold_b}),
            32'(exp_ctl[1]));
    endtask

    task automatic set_in(input logic r, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                          input logic urs, input logic urt, input logic mrd, input logic [REG_W-1:0] rd,
                          input logic redir, input logic mreq, input logic mrdy);
        rst_n = r; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        ex_mem_read = mrd; ex_rd = rd; redirect = redir; mem_req = mreq; mem_ready = mrdy;
    endtask

    task automatic idle();
        set_in(1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic tick_chk();
        #1 check_cycle();
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic cyc();
        tick_chk();
        nxt();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cyc();
        idle();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            clear_model(k);
            m_stalls[k] = 0;
        end
        idle();
        rst_n = 1'b0;
        nxt();
        cyc();
        cyc();
        idle();

        // Reset state
        tick_chk();
        chk("rst_stall_a", 32'(stall_a), 32'd0);
        chk("rst_timeout_a", 32'(mem_timeout_a), 32'd0);
        chk("rst_pc_write_a", 32'(pc_write_a), 32'd1);
        nxt();

        // Load r5 then add r5,r6: one bubble on LU_CYCLES=1
        set_in(1'b1, 6'd5, 6'd6, 1'b1, 1'b1, 1'b1, 6'd5, 1'b0, 1'b0, 1'b1);
        tick_chk();
        chk("lu_pc_write_a", 32'(pc_write_a), 32'd0);
        chk("lu_idex_flush_a", 32'(idex_flush_a), 32'd1);
        nxt();
        idle();
        tick_chk();
        chk("lu_release_a", 32'(pc_write_a), 32'd1);
        chk("lu_second_b", 32'(pc_write_b), 32'd0);
        nxt();
        tick_chk();
        chk("lu_stall_a", 32'(stall_a), 32'd1);
        nxt();

        // LU_CYCLES=2 with a redirect on the second bubble
        do_reset();
        set_in(1'b1, 6'd5, 6'd6, 1'b1, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 1'b1);
        cyc();
        idle();
        redirect = 1'b1;
        tick_chk();
        chk("redir_pc_write_b", 32'(pc_write_b), 32'd1);
        chk("redir_exmem_flush_b", 32'(exmem_flush_b), 32'd1);
        nxt();
        idle();
        tick_chk();
        chk("redir_stall_b", 32'(stall_b), 32'd1);
        nxt();

        // Three memory wait cycles then release
        do_reset();
        set_in(1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc();
        mem_ready = 1'b1;
        tick_chk();
        chk("mw_release_a", 32'(pc_write_a), 32'd1);
        nxt();
        idle();
        tick_chk();
        chk("mw_stall_a", 32'(stall_a), 32'd3);
        nxt();

        // Memory timeout after 64 low cycles, frozen until reset
        do_reset();
        set_in(1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        repeat (64) cyc();
        mem_ready = 1'b1;
        tick_chk();
        chk("to_flag_a", 32'(mem_timeout_a), 32'd1);
        chk("to_freeze_a", 32'(exmem_hold_a), 32'd1);
        chk("to_sat_b", 32'(stall_b), 32'd15);
        nxt();
        cyc();
        do_reset();
        tick_chk();
        chk("to_clear_a", 32'(mem_timeout_a), 32'd0);
        chk("to_clear_stall_a", 32'(stall_a), 32'd0);
        nxt();

        // Redirect beats hazard; memory wait beats both
        set_in(1'b1, 6'd7, 6'd7, 1'b1, 1'b0, 1'b1, 6'd7, 1'b1, 1'b0, 1'b1);
        tick_chk();
        chk("prio_redir_a", 32'(ifid_flush_a), 32'd1);
        nxt();
        idle();
        tick_chk();
        chk("prio_stall_a", 32'(stall_a), 32'd0);
        nxt();
        set_in(1'b1, 6'd7, 6'd7, 1'b1, 1'b0, 1'b1, 6'd7, 1'b1, 1'b1, 1'b0);
        tick_chk();
        chk("prio_freeze_a", 32'(exmem_hold_a), 32'd1);
        chk("prio_freeze_pc_a", 32'(pc_write_a), 32'd0);
        nxt();
        idle();
        cyc();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst_n       = ($urandom_range(0, 149) != 0);
            id_rs       = REG_W'($urandom_range(0, 3));
            id_rt       = REG_W'($urandom_range(0, 3));
            ex_rd       = REG_W'($urandom_range(0, 3));
            id_use_rs   = 1'($urandom_range(0, 1));
            id_use_rt   = 1'($urandom_range(0, 1));
            ex_mem_read = ($urandom_range(0, 2) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            mem_req     = ($urandom_range(0, 2) == 0);
            mem_ready   = ($urandom_range(0, 9) >= 3);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
